// File: rtl/mpmodred256_serial.sv
// Serial conditional-subtract modular reduction: r = s mod m for s < 2m, one 32-bit limb per cycle.
// Sits downstream of the serial multi-precision adder and mirrors its limb-serial datapath.
module mpmodred256_serial #(
  parameter int unsigned W    = 256,
  parameter int unsigned LIMB = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W:0]   s_in,
  input  logic [W-1:0] m_in,
  input  logic         load,
  input  logic         start,
  output logic [W-1:0] r_out,
  output logic         busy,
  output logic         ready
);

  localparam int unsigned N    = W / LIMB;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StSub, StSel} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [W:0]      r_s;
  logic [W-1:0]    r_m;
  logic [W-1:0]    r_d;
  logic            r_bor;
  logic [IdxW-1:0] r_idx;
  logic            r_ready;

  logic [LIMB-1:0] w_s_limb;
  logic [LIMB-1:0] w_m_limb;
  logic [LIMB:0]   w_diff;
  logic            w_take_d;

  assign w_s_limb = r_s[r_idx*LIMB +: LIMB];
  assign w_m_limb = r_m[r_idx*LIMB +: LIMB];
  // Top bit of the LIMB+1 result is the outgoing borrow.
  assign w_diff   = {1'b0, w_s_limb} - {1'b0, w_m_limb} - {{LIMB{1'b0}}, r_bor};
  // A carry-out in s absorbs the 2^W wrap, so the difference is non-negative.
  assign w_take_d = r_s[W] | ~r_bor;

  assign busy  = (r_state != StIdle);
  assign ready = r_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_nxt = StSub;
      StSub:   if (r_idx == LastIdx) w_state_nxt = StSel;
      StSel:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx   <= '0;
      r_bor   <= 1'b0;
      r_out   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_idx <= '0;
            r_bor <= 1'b0;
          end
        end
        StSub: begin
          r_bor <= w_diff[LIMB];
          r_idx <= r_idx + 1'b1;
        end
        StSel: begin
          r_out   <= w_take_d ? r_d : r_s[W-1:0];
          r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand and difference registers carry no reset; they are always written before use.
  always_ff @(posedge CLK) begin
    if (r_state == StIdle && load) begin
      r_s <= s_in;
      r_m <= m_in;
    end
    if (r_state == StSub) begin
      r_d[r_idx*LIMB +: LIMB] <= w_diff[LIMB-1:0];
    end
  end

endmodule

// File: tb/tb_mpmodred256_serial.sv
// Scoreboard bench for mpmodred256_serial: directed vectors push expected results,
// a negedge monitor pops and compares on every ready pulse.
module tb_mpmodred256_serial;

  logic         CLK;
  logic         RST;
  logic [256:0] s_in;
  logic [255:0] m_in;
  logic         load;
  logic         start;
  logic [255:0] r_out;
  logic         busy;
  logic         ready;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];

  mpmodred256_serial #(
    .W    (256),
    .LIMB (32)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .s_in  (s_in),
    .m_in  (m_in),
    .load  (load),
    .start (start),
    .r_out (r_out),
    .busy  (busy),
    .ready (ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 256'd1, 256'd0);
      end else begin
        check("r_out", r_out, exp_q.pop_front());
      end
    end
  end

  // Drive one start (optionally with load); leaves time at E0 + 1.
  task automatic issue(input logic [256:0] s, input logic [255:0] m, input logic do_load,
                       input logic expect_done, input logic [255:0] exp);
    @(negedge CLK);
    s_in  = s;
    m_in  = m;
    load  = do_load;
    start = 1'b1;
    if (expect_done) exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    load  = 1'b0;
    start = 1'b0;
    check("busy_rise", {255'd0, busy}, 256'd1);
  endtask

  task automatic wait_ready(input string name, input int elapsed);
    int   cyc     = elapsed;
    logic got     = 1'b0;
    logic busy_ok = 1'b1;
    while (!got && cyc < 20) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (ready) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check({name, "_done"}, {255'd0, got}, 256'd1);
    check({name, "_latency"}, 256'(cyc), 256'd9);
    check({name, "_busy_hold"}, {255'd0, busy_ok}, 256'd1);
    check({name, "_busy_fall"}, {255'd0, busy}, 256'd0);
  endtask

  task automatic run_op(input string name, input logic [256:0] s, input logic [255:0] m,
                        input logic [255:0] exp);
    issue(s, m, 1'b1, 1'b1, exp);
    wait_ready(name, 0);
  endtask

  initial begin
    logic [255:0] m_big;
    logic         quiet;
    RST   = 1'b1;
    s_in  = '0;
    m_in  = '0;
    load  = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_ready", {255'd0, ready}, 256'd0);
    check("rst_r_out", r_out, 256'd0);
    @(negedge CLK);
    RST = 1'b0;

    m_big = {{224{1'b1}}, 32'hFFFF_FFF1};
    run_op("basic_sub", {1'b0, {224{1'b1}}, 32'hFFFF_FFF6}, m_big, 256'd5);
    run_op("below_m", 257'h1234, 256'h10000, 256'h1234);
    run_op("equal_m", {1'b0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 128'h5},
           {128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 128'h5}, 256'd0);
    run_op("carry_in", {1'b1, 256'd3}, {256{1'b1}}, 256'd4);
    run_op("borrow_ripple", {33'd1, 224'd0}, 256'd1, {32'd0, {224{1'b1}}});
    run_op("carry_zero_low", {1'b1, 256'd0}, {1'b1, 254'd0, 1'b1}, {1'b0, {255{1'b1}}});

    // start+load with different operands three cycles into an operation must be ignored.
    issue({1'b0, {224{1'b1}}, 32'hFFFF_FFF6}, m_big, 1'b1, 1'b1, 256'd5);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    s_in  = 257'h1234;
    m_in  = 256'h10000;
    load  = 1'b1;
    start = 1'b1;
    @(posedge CLK);
    #1;
    load  = 1'b0;
    start = 1'b0;
    wait_ready("busy_protect", 3);
    quiet = 1'b1;
    repeat (12) begin
      @(posedge CLK);
      #1;
      if (ready || busy) quiet = 1'b0;
    end
    check("protect_quiet", {255'd0, quiet}, 256'd1);
    check("protect_hold", r_out, 256'd5);
    // start without load reuses the retained operands.
    issue(257'h1234, 256'h10000, 1'b0, 1'b1, 256'd5);
    wait_ready("reuse_operands", 0);

    // Reset during the fourth SUB cycle aborts with no ready.
    issue(257'h1234, 256'h10000, 1'b1, 1'b0, 256'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("abort_busy", {255'd0, busy}, 256'd0);
    check("abort_ready", {255'd0, ready}, 256'd0);
    check("abort_r_out", r_out, 256'd0);
    quiet = 1'b1;
    repeat (15) begin
      @(posedge CLK);
      #1;
      if (ready || busy) quiet = 1'b0;
    end
    check("abort_quiet", {255'd0, quiet}, 256'd1);
    run_op("after_abort", {1'b1, 256'd3}, {256{1'b1}}, 256'd4);

    repeat (3) @(posedge CLK);
    check("queue_drain", 256'(exp_q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpmodred256_serial.md
# mpmodred256_serial

Serial modular reduction stage placed directly downstream of the 256-bit multi-precision adder. It takes the 257-bit sum `s = a + b` and a 256-bit modulus `m`, and returns `r = s mod m`. It assumes `s < 2m`, so at most one conditional subtraction is needed. The subtraction runs limb by limb over 32-bit limbs with a borrow chain, mirroring the adder's serial datapath, and the result feeds the next field-arithmetic stage.

## Interface
Parameters:
- `W`, 256: operand width. Must be a multiple of `LIMB`.
- `LIMB`, 32: limb width. `N = W/LIMB` limbs, which is 8 by default.

Ports:
- `CLK`  in  1  Clock. All state updates on the rising edge.
- `RST`  in  1  Reset, synchronous, active-high.
- `s_in`  in  W+1  Unreduced sum. Bit W is the adder carry-out.
- `m_in`  in  W  Modulus. Required: `m_in != 0`.
- `load`  in  1  Capture `s_in`/`m_in` into internal registers `s`/`m`. Honoured only in IDLE.
- `start`  in  1  Begin reduction. Single-cycle pulse, honoured only in IDLE.
- `r_out`  out  W  Reduced result. Holds its value until the next completion.
- `busy`  out  1  High while a reduction is in progress.
- `ready`  out  1  One-cycle completion pulse. `r_out` is valid from this cycle on.

## Operation
- Registers:
  - `s[W:0]`, `m[W-1:0]` hold the operands.
  - `d[W-1:0]` holds the difference.
  - `bor` is the borrow, 1 bit.
  - `idx` is the limb counter, `clog2(N)` bits.
  - `state` is the FSM state.
  - `r_out` is the result register.
- States:
  - IDLE: `busy=0`.
    - `load` → capture operands.
    - `start` → go to SUB with `idx=0`, `bor=0`.
    - If `load` and `start` occur together, the load is captured first and the start then uses the new operands on the same edge; that is, SUB computes on `s_in`/`m_in` as sampled.
  - SUB: each cycle computes `{b', dk} = s[k] - m[k] - bor` over `LIMB+1` bits, where `k = idx`. Store `d[k] = dk`, `bor = b'`, `idx++`. After limb N-1, go to SEL.
  - SEL: `take_d = s[W] | ~bor`.
    - `r_out <= take_d ? d : s[W-1:0]`.
    - `ready <= 1`.
    - Go to IDLE.
- `ready` is high only in the cycle following SEL. It is cleared on the next edge.
- `start` or `load` while `busy` is ignored. Operand registers are not disturbed mid-operation.
- Arithmetic:
  - The final borrow with `s[W]=1` means the true difference is non-negative; the 2^W wrap is absorbed. Take `d`.
  - `s == m` gives `r_out = 0`.
  - `s < m` gives `r_out = s`.
  - Behaviour for `s >= 2m` is unspecified: one subtraction only, no error flag.

## Timing
- Reset: `state=IDLE`, `busy=0`, `ready=0`, `r_out=0`, `idx=0`, `bor=0`. Operand registers are not reset.
- `RST` mid-operation aborts immediately. Outputs return to reset values on that edge and no `ready` is issued.
- Latency:
  - Start sampled at edge E0.
  - Limb k is written at edge E(k+1), for k = 0..N-1.
  - SEL updates `r_out` and sets `ready` at edge E(N+1).
  - With N=8: `ready` is high between E9 and E10.
- `busy`:
  - Rises at E0 and falls at E(N+1), the same edge `ready` rises.
  - A new `start` is therefore accepted at E(N+1)+1 at the earliest. This gives throughput of one result per N+2 cycles.
- `r_out` is stable outside the SEL→IDLE edge.

## Test plan
- Basic subtract: `s=m+5` with `m=0xFFFF...FFF1` → `ready` at 9 cycles after start, `r_out=5`.
- Below modulus and equal to modulus:
  - `s=0x1234`, `m=0x10000` → `r_out=0x1234`.
  - `s=m` → `r_out=0`.
- Carry-in case: `s=2^256+3`, `m=2^256-1` → `r_out=4`.
- Borrow ripple: `s=2^224`, `m=1` → `r_out=2^224-1`, with the borrow propagating through limbs 0..6.
- Busy protection: second `start` plus `load` with new data issued 3 cycles into an operation → first result is unchanged, no extra `ready`, `busy` low for exactly the cycles in IDLE.
- Reset mid-op: `RST` at cycle 4 of SUB → next cycle `busy=0`, `ready=0`, `r_out=0`, and no `ready` pulse follows. A fresh load/start then completes normally.
